// File: rtl/mouse_pkg.sv
// Shared types and PS/2 mouse protocol constants for the mouse command path.
package mouse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SENT = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Mouse response and command codes
  localparam logic [7:0] PS2_ACK              = 8'hFA;
  localparam logic [7:0] PS2_RESEND           = 8'hFE;
  localparam logic [7:0] PS2_SET_SAMPLE_RATE  = 8'hF3;
  localparam logic [7:0] PS2_SET_RESOLUTION   = 8'hE8;
  localparam logic [7:0] PS2_ENABLE_REPORTING = 8'hF4;

  // Receiver error codes
  localparam logic [1:0] RX_ERR_NONE    = 2'b00;
  localparam logic [1:0] RX_ERR_PARITY  = 2'b01;
  localparam logic [1:0] RX_ERR_FRAME   = 2'b10;
  localparam logic [1:0] RX_ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/mouse_cmd_timer.sv
// Clearable saturating timeout timer. Implemented as a down-counter loaded
// with TIMEOUT_CYCLES-1; TIMEOUT is the terminal-count (zero) compare and the
// count holds at zero rather than wrapping.
module mouse_cmd_timer
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: reload on clear, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q == '0);

endmodule

// File: rtl/mouse_cmd_arbiter.sv
// Round-robin arbiter plus command sequencer for the shared PS/2 mouse
// transmitter. Sends the granted byte, collects the mouse response, retries
// on anything but a clean acknowledge and reports pass/fail to the owner.
//
// state        | meaning
// ST_IDLE      | waiting for a request; grants round-robin and latches byte
// ST_SEND      | SEND_BYTE pulse to the transmitter
// ST_WAIT_SENT | waiting for BYTE_SENT, timer running
// ST_WAIT_ACK  | receiver enabled, waiting for the response byte
// ST_DONE      | DONE/ERR pulse to the owning requester
module mouse_cmd_arbiter
  import mouse_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 2000000,
  parameter int         MAX_RETRY      = 3,
  parameter logic [7:0] ACK_BYTE       = PS2_ACK,
  parameter logic [7:0] RESEND_BYTE    = PS2_RESEND
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] BYTE0,
  input  logic [7:0] BYTE1,
  output logic       DONE0,
  output logic       DONE1,
  output logic       ERR0,
  output logic       ERR1,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic       BYTE_READY,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  output logic       BUSY,
  output logic       OWNER
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_t        state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic          owner_q, owner_d;
  logic          rr_last_q, rr_last_d;
  logic          fail_q, fail_d;
  logic [RW-1:0] retry_q, retry_d;

  logic send_byte_q, send_byte_d;
  logic read_en_q, read_en_d;
  logic busy_q, busy_d;
  logic done0_q, done0_d;
  logic done1_q, done1_d;
  logic err0_q, err0_d;
  logic err1_q, err1_d;

  logic grant;
  logic do_retry;
  logic rx_ack;
  logic in_wait;
  logic timer_clr;
  logic timeout;

  // A resend request never counts as acknowledge, even if ACK_BYTE is retuned.
  assign rx_ack = (BYTE_ERROR_CODE == RX_ERR_NONE) && (BYTE_READ == ACK_BYTE) &&
                  (BYTE_READ != RESEND_BYTE);

  assign in_wait   = (state_q == ST_WAIT_SENT) || (state_q == ST_WAIT_ACK);
  // Timer restarts on every state change so each wait phase gets a full budget.
  assign timer_clr = (state_d != state_q) || !in_wait;

  mouse_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .clr    (timer_clr),
    .en     (in_wait),
    .timeout(timeout)
  );

  // Next-state, arbitration, retry bookkeeping and registered-output values.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    fail_d    = fail_q;
    retry_d   = retry_q;
    grant     = 1'b0;
    do_retry  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          grant     = (REQ0 && REQ1) ? ~rr_last_q : REQ1;
          owner_d   = grant;
          rr_last_d = grant;
          byte_d    = grant ? BYTE1 : BYTE0;
          retry_d   = '0;
          fail_d    = 1'b0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: begin
        if (BYTE_SENT) begin
          state_d = ST_WAIT_ACK;
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (BYTE_READY) begin
          if (rx_ack) begin
            fail_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            do_retry = 1'b1;
          end
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_retry) begin
      if (retry_q < RETRY_LIMIT) begin
        retry_d = retry_q + RW'(1);
        state_d = ST_SEND;
      end else begin
        fail_d  = 1'b1;
        state_d = ST_DONE;
      end
    end

    send_byte_d = (state_d == ST_SEND);
    read_en_d   = (state_d == ST_WAIT_ACK);
    busy_d      = (state_d != ST_IDLE);
    done0_d     = (state_d == ST_DONE) && !owner_d;
    done1_d     = (state_d == ST_DONE) && owner_d;
    err0_d      = done0_d && fail_d;
    err1_d      = done1_d && fail_d;
  end

  // State and output registers; pointer resets so requester 0 wins first.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      byte_q      <= 8'h00;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      fail_q      <= 1'b0;
      retry_q     <= '0;
      send_byte_q <= 1'b0;
      read_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      fail_q      <= fail_d;
      retry_q     <= retry_d;
      send_byte_q <= send_byte_d;
      read_en_q   <= read_en_d;
      busy_q      <= busy_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
    end
  end

  assign SEND_BYTE    = send_byte_q;
  assign BYTE_TO_SEND = byte_q;
  assign READ_ENABLE  = read_en_q;
  assign BUSY         = busy_q;
  assign OWNER        = owner_q;
  assign DONE0        = done0_q;
  assign DONE1        = done1_q;
  assign ERR0         = err0_q;
  assign ERR1         = err1_q;

endmodule

// File: tb/tb_mouse_cmd_arbiter.sv
// Directed bench for mouse_cmd_arbiter with a short timeout (100 cycles).
module tb_mouse_cmd_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic [7:0] BYTE0 = 8'h00, BYTE1 = 8'h00;
  logic       DONE0, DONE1, ERR0, ERR1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic       BYTE_READY = 1'b0;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       BUSY, OWNER;

  int n_checks = 0;
  int n_errors = 0;
  int send_cnt = 0;
  int s0;
  int n;

  mouse_cmd_arbiter #(
    .TIMEOUT_CYCLES(100),
    .MAX_RETRY     (3)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .REQ0           (REQ0),
    .REQ1           (REQ1),
    .BYTE0          (BYTE0),
    .BYTE1          (BYTE1),
    .DONE0          (DONE0),
    .DONE1          (DONE1),
    .ERR0           (ERR0),
    .ERR1           (ERR1),
    .SEND_BYTE      (SEND_BYTE),
    .BYTE_TO_SEND   (BYTE_TO_SEND),
    .BYTE_SENT      (BYTE_SENT),
    .READ_ENABLE    (READ_ENABLE),
    .BYTE_READY     (BYTE_READY),
    .BYTE_READ      (BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BUSY           (BUSY),
    .OWNER          (OWNER)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (SEND_BYTE) send_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_send(input string tag);
    int i;
    for (i = 0; i < 300 && !SEND_BYTE; i++) tick();
    if (!SEND_BYTE) chk({tag, "_send_timeout"}, 0, 1);
  endtask

  // One attempt: wait for SEND, answer SENT after dly cycles, then one response byte.
  task automatic serve(input int dly, input logic [7:0] resp, input logic [1:0] code,
                       input logic [7:0] exp_byte, input string tag);
    int i;
    wait_send(tag);
    chk({tag, "_byte"}, BYTE_TO_SEND, exp_byte);
    repeat (dly) tick();
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
    for (i = 0; i < 300 && !READ_ENABLE; i++) tick();
    if (!READ_ENABLE) chk({tag, "_rden_timeout"}, 0, 1);
    BYTE_READ       = resp;
    BYTE_ERROR_CODE = code;
    BYTE_READY      = 1'b1;
    tick();
    BYTE_READY      = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 300 && !(DONE0 || DONE1); i++) tick();
    if (!(DONE0 || DONE1)) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    logic [7:0] fair_byte [4];
    fair_byte[0] = 8'h11; fair_byte[1] = 8'h22; fair_byte[2] = 8'h11; fair_byte[3] = 8'h22;

    // Reset state
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_send", SEND_BYTE, 0);
    chk("rst_rden", READ_ENABLE, 0);
    chk("rst_done", {DONE1, DONE0}, 0);
    chk("rst_err", {ERR1, ERR0}, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_owner", OWNER, 0);
    chk("rst_byte", BYTE_TO_SEND, 8'h00);

    // Single request, SENT after 10 cycles, clean ACK
    s0 = send_cnt;
    REQ0 = 1'b1; BYTE0 = 8'hF4;
    tick();
    chk("single_latency_send", SEND_BYTE, 1);
    chk("single_latency_busy", BUSY, 1);
    serve(10, 8'hFA, 2'b00, 8'hF4, "single");
    wait_done("single");
    chk("single_done0", DONE0, 1);
    chk("single_done1", DONE1, 0);
    chk("single_err0", ERR0, 0);
    chk("single_owner", OWNER, 0);
    REQ0 = 1'b0;
    chk("single_sends", send_cnt - s0, 1);
    tick();
    chk("single_busy_after", BUSY, 0);
    tick();
    chk("single_idle_send", SEND_BYTE, 0);

    // Fairness after a fresh reset: 0,1,0,1
    do_reset();
    REQ0 = 1'b1; BYTE0 = 8'h11;
    REQ1 = 1'b1; BYTE1 = 8'h22;
    for (int t = 0; t < 4; t++) begin
      wait_send("fair");
      chk("fair_owner", OWNER, t % 2);
      serve(1, 8'hFA, 2'b00, fair_byte[t], "fair");
      wait_done("fair");
      chk("fair_done", {DONE1, DONE0}, (t % 2) ? 2'b10 : 2'b01);
      chk("fair_err", {ERR1, ERR0}, 0);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (3) tick();

    // Resend twice, then ACK
    s0 = send_cnt;
    REQ0 = 1'b1; BYTE0 = 8'hF3;
    serve(1, 8'hFE, 2'b00, 8'hF3, "resend1");
    BYTE0 = 8'h55;
    serve(2, 8'hFE, 2'b00, 8'hF3, "resend2");
    serve(1, 8'hFA, 2'b00, 8'hF3, "resend3");
    wait_done("resend");
    chk("resend_done0", DONE0, 1);
    chk("resend_err0", ERR0, 0);
    REQ0 = 1'b0;
    chk("resend_sends", send_cnt - s0, 3);
    repeat (3) tick();

    // Exhaustion on requester 1: no response ever
    s0 = send_cnt;
    REQ1 = 1'b1; BYTE1 = 8'hE8;
    for (int a = 0; a < 4; a++) begin
      wait_send("exh");
      chk("exh_byte", BYTE_TO_SEND, 8'hE8);
      tick();
      BYTE_SENT = 1'b1;
      tick();
      BYTE_SENT = 1'b0;
      n = 0;
      while (READ_ENABLE && n < 300) begin
        n++;
        tick();
      end
      chk("exh_ack_window", n, 100);
      if (a < 3) chk("exh_retry_send", SEND_BYTE, 1);
    end
    chk("exh_done1", DONE1, 1);
    chk("exh_err1", ERR1, 1);
    chk("exh_done0", DONE0, 0);
    REQ1 = 1'b0;
    chk("exh_sends", send_cnt - s0, 4);
    tick();
    tick();

    // Retry count cleared on new grant; error code forces a retry
    s0 = send_cnt;
    REQ1 = 1'b1; BYTE1 = 8'hF3;
    serve(1, 8'hFA, 2'b01, 8'hF3, "errcode");
    serve(1, 8'hFA, 2'b00, 8'hF3, "errcode_ok");
    wait_done("errcode");
    chk("errcode_done1", DONE1, 1);
    chk("errcode_err1", ERR1, 0);
    REQ1 = 1'b0;
    chk("errcode_sends", send_cnt - s0, 2);
    repeat (3) tick();

    // Precedence: stray READY in WAIT_SENT ignored; SENT and READY beat timeout
    s0 = send_cnt;
    REQ0 = 1'b1; BYTE0 = 8'hE8;
    wait_send("prec");
    tick();
    BYTE_READ = 8'hFA; BYTE_READY = 1'b1;
    tick();
    BYTE_READY = 1'b0;
    chk("prec_stray_rden", READ_ENABLE, 0);
    chk("prec_stray_done", DONE0, 0);
    repeat (98) tick();
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
    chk("prec_sent_rden", READ_ENABLE, 1);
    chk("prec_sent_send", SEND_BYTE, 0);
    repeat (99) tick();
    BYTE_READ = 8'hFA; BYTE_READY = 1'b1;
    tick();
    BYTE_READY = 1'b0;
    chk("prec_ready_done0", DONE0, 1);
    chk("prec_ready_err0", ERR0, 0);
    REQ0 = 1'b0;
    chk("prec_sends", send_cnt - s0, 1);
    repeat (3) tick();

    // Reset abort in WAIT_SENT; requester 0 granted first afterwards
    REQ0 = 1'b1; BYTE0 = 8'hF4;
    wait_send("abort");
    tick();
    chk("abort_pre_busy", BUSY, 1);
    RESET = 1'b1;
    #2;
    chk("abort_busy", BUSY, 0);
    chk("abort_send", SEND_BYTE, 0);
    chk("abort_rden", READ_ENABLE, 0);
    chk("abort_done", {DONE1, DONE0}, 0);
    chk("abort_owner", OWNER, 0);
    chk("abort_byte", BYTE_TO_SEND, 8'h00);
    REQ1 = 1'b1; BYTE1 = 8'h22;
    tick();
    chk("abort_no_done", {DONE1, DONE0}, 0);
    RESET = 1'b0;
    wait_send("abort_regrant");
    chk("abort_regrant_owner", OWNER, 0);
    serve(1, 8'hFA, 2'b00, 8'hF4, "abort_regrant");
    wait_done("abort_regrant");
    chk("abort_regrant_done0", DONE0, 1);
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
